// File: rtl/alu_seq.sv
// Sequencer that turns ALU, load and store operations into per-cycle datapath
// controls and a memory request/ack handshake with a bounded wait.
module alu_seq #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [1:0]  op_kind,
   input  logic [3:0]  op_alu_f,
   input  logic [2:0]  op_a,
   input  logic [2:0]  op_b,
   input  logic [2:0]  op_d,
   input  logic [15:0] op_imm,
   input  logic        op_carry,
   input  logic        op_flags,
   input  logic        op_postinc,
   output logic [3:0]  alu_f,
   output logic [2:0]  a_idx,
   output logic [2:0]  b_idx,
   output logic [2:0]  d_idx,
   output logic [15:0] t16,
   output logic        sel_inp,
   output logic        carry_mask,
   output logic        wr_reg,
   output logic        wr_flags,
   output logic        wr_back_addr,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        done,
   output logic        err,
   output logic        busy
);

   localparam int unsigned CW = 8;
   localparam logic [1:0] K_RR = 2'b00;
   localparam logic [1:0] K_LD = 2'b10;
   localparam logic [1:0] K_ST = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EXEC    = 3'd1,
      S_ADDR    = 3'd2,
      S_WB      = 3'd3,
      S_POSTINC = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [1:0]    kind_q;
   logic [3:0]    alu_f_q;
   logic [2:0]    a_q, b_q, d_q;
   logic [15:0]   imm_q;
   logic          carry_q, flags_q, postinc_q;
   logic [15:0]   data_q;
   logic [CW-1:0] cnt_q;

   logic accept;
   logic timeout_hit;

   assign accept      = op_valid && (state == S_IDLE);
   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

   // State register; reset returns to IDLE without waiting for a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Operation, load data and wait-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind_q    <= '0;
         alu_f_q   <= '0;
         a_q       <= '0;
         b_q       <= '0;
         d_q       <= '0;
         imm_q     <= '0;
         carry_q   <= 1'b0;
         flags_q   <= 1'b0;
         postinc_q <= 1'b0;
         data_q    <= '0;
         cnt_q     <= '0;
      end else begin
         if (accept) begin
            kind_q    <= op_kind;
            alu_f_q   <= op_alu_f;
            a_q       <= op_a;
            b_q       <= op_b;
            d_q       <= op_d;
            imm_q     <= op_imm;
            carry_q   <= op_carry;
            flags_q   <= op_flags;
            postinc_q <= op_postinc;
            cnt_q     <= '0;
         end else if (state == S_ADDR && !mem_ack) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (state == S_ADDR && mem_ack && kind_q == K_LD) data_q <= mem_rdata;
      end
   end

   // Next state and datapath controls
   always_comb begin
      state_nxt    = state;
      op_ready     = 1'b0;
      busy         = (state != S_IDLE);
      alu_f        = '0;
      a_idx        = '0;
      b_idx        = '0;
      d_idx        = '0;
      t16          = '0;
      sel_inp      = 1'b0;
      carry_mask   = 1'b0;
      wr_reg       = 1'b0;
      wr_flags     = 1'b0;
      wr_back_addr = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      unique case (state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) state_nxt = op_kind[1] ? S_ADDR : S_EXEC;
         end
         S_EXEC: begin
            alu_f      = alu_f_q;
            a_idx      = a_q;
            b_idx      = b_q;
            d_idx      = d_q;
            sel_inp    = (kind_q == K_RR);
            t16        = imm_q;
            carry_mask = carry_q;
            wr_reg     = 1'b1;
            wr_flags   = flags_q;
            done       = 1'b1;
            state_nxt  = S_IDLE;
         end
         S_ADDR: begin
            a_idx   = a_q;
            b_idx   = b_q;
            t16     = imm_q;
            mem_req = 1'b1;
            mem_we  = (kind_q == K_ST);
            if (mem_ack) begin
               if (kind_q == K_LD)  state_nxt = S_WB;
               else if (postinc_q)  state_nxt = S_POSTINC;
               else begin
                  done      = 1'b1;
                  state_nxt = S_IDLE;
               end
            end else if (timeout_hit) begin
               err       = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WB: begin
            alu_f    = 4'b0111;
            t16      = data_q;
            d_idx    = d_q;
            wr_reg   = 1'b1;
            wr_flags = flags_q;
            if (postinc_q) state_nxt = S_POSTINC;
            else begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_POSTINC: begin
            alu_f        = 4'b0001;
            b_idx        = a_q;
            d_idx        = a_q;
            wr_back_addr = 1'b1;
            wr_reg       = 1'b1;
            done         = 1'b1;
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: every cycle's expected control snapshot is queued
// when an operation is issued and compared against the DUT at the falling edge.
module tb_alu_seq;

   localparam int unsigned TO = 4;

   logic        clk, rst_n, op_valid, op_ready;
   logic [1:0]  op_kind;
   logic [3:0]  op_alu_f, alu_f;
   logic [2:0]  op_a, op_b, op_d, a_idx, b_idx, d_idx;
   logic [15:0] op_imm, t16, mem_rdata;
   logic        op_carry, op_flags, op_postinc;
   logic        sel_inp, carry_mask, wr_reg, wr_flags, wr_back_addr;
   logic        mem_req, mem_we, mem_ack, done, err, busy;

   alu_seq #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_kind(op_kind), .op_alu_f(op_alu_f), .op_a(op_a), .op_b(op_b), .op_d(op_d),
      .op_imm(op_imm), .op_carry(op_carry), .op_flags(op_flags), .op_postinc(op_postinc),
      .alu_f(alu_f), .a_idx(a_idx), .b_idx(b_idx), .d_idx(d_idx), .t16(t16),
      .sel_inp(sel_inp), .carry_mask(carry_mask), .wr_reg(wr_reg), .wr_flags(wr_flags),
      .wr_back_addr(wr_back_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .done(done), .err(err), .busy(busy)
   );

   typedef struct packed {
      logic op_ready, busy, done, err, mem_req, mem_we;
      logic wr_reg, wr_flags, wr_back_addr, sel_inp, carry_mask;
      logic [3:0]  alu_f;
      logic [2:0]  a_idx, b_idx, d_idx;
      logic [15:0] t16;
   } snap_t;

   snap_t exp_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic snap_t cur_snap();
      snap_t s;
      s = '{op_ready, busy, done, err, mem_req, mem_we, wr_reg, wr_flags, wr_back_addr,
            sel_inp, carry_mask, alu_f, a_idx, b_idx, d_idx, t16};
      return s;
   endfunction

   function automatic snap_t idle_snap();
      snap_t s = '0;
      s.op_ready = 1'b1;
      return s;
   endfunction

   // One clock cycle: drive inputs after the rising edge, compare at the falling edge
   task automatic step(input logic v, input logic ack, input logic [15:0] rd, input string tag);
      snap_t e;
      op_valid  = v;
      mem_ack   = ack;
      mem_rdata = rd;
      @(negedge clk);
      check_eq({tag, "_qdepth"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_eq(tag, 64'(cur_snap()), 64'(e));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_fields();
      op_kind    = 2'($urandom);
      op_alu_f   = 4'($urandom);
      op_a       = 3'($urandom);
      op_b       = 3'($urandom);
      op_d       = 3'($urandom);
      op_imm     = 16'($urandom);
      op_carry   = 1'($urandom);
      op_flags   = 1'($urandom);
      op_postinc = 1'($urandom);
   endtask

   // w = ADDR cycle (1-based) carrying mem_ack; 0 means no ack, ending in timeout
   task automatic run_op(input string tag, input logic [1:0] kind, input logic [3:0] f,
                         input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                         input logic [15:0] imm, input logic carry, input logic flags,
                         input logic postinc, input int w, input logic [15:0] rd,
                         input logic hold);
      snap_t s;
      int    n;
      op_kind = kind; op_alu_f = f; op_a = a; op_b = b; op_d = d; op_imm = imm;
      op_carry = carry; op_flags = flags; op_postinc = postinc;
      exp_q.push_back(idle_snap());
      step(1'b1, 1'b0, 16'h0, {tag, "_accept"});
      if (hold) scramble_fields();
      if (!kind[1]) begin
         s = '0;
         s.busy = 1'b1; s.done = 1'b1; s.wr_reg = 1'b1; s.wr_flags = flags;
         s.sel_inp = (kind == 2'b00); s.carry_mask = carry; s.alu_f = f;
         s.a_idx = a; s.b_idx = b; s.d_idx = d; s.t16 = imm;
         exp_q.push_back(s);
         step(hold, 1'b1, 16'hDEAD, {tag, "_exec"});
      end else begin
         n = (w == 0) ? int'(TO) : w;
         for (int i = 1; i <= n; i++) begin
            s = '0;
            s.busy = 1'b1; s.mem_req = 1'b1; s.mem_we = (kind == 2'b11);
            s.a_idx = a; s.b_idx = b; s.t16 = imm;
            if (i == n && w == 0) s.err = 1'b1;
            if (i == n && w != 0 && kind == 2'b11 && !postinc) s.done = 1'b1;
            exp_q.push_back(s);
            step(hold, (i == w), (i == w) ? rd : 16'($urandom), {tag, "_addr"});
         end
         if (w != 0 && kind == 2'b10) begin
            s = '0;
            s.busy = 1'b1; s.alu_f = 4'b0111; s.t16 = rd; s.d_idx = d;
            s.wr_reg = 1'b1; s.wr_flags = flags; s.done = !postinc;
            exp_q.push_back(s);
            step(hold, 1'b1, 16'h1111, {tag, "_wb"});
         end
         if (w != 0 && postinc) begin
            s = '0;
            s.busy = 1'b1; s.alu_f = 4'b0001; s.b_idx = a; s.d_idx = a;
            s.wr_back_addr = 1'b1; s.wr_reg = 1'b1; s.done = 1'b1;
            exp_q.push_back(s);
            step(hold, 1'b1, 16'h2222, {tag, "_postinc"});
         end
      end
   endtask

   initial begin
      rst_n = 1'b1; op_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      op_kind = '0; op_alu_f = '0; op_a = '0; op_b = '0; op_d = '0; op_imm = '0;
      op_carry = 1'b0; op_flags = 1'b0; op_postinc = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_eq("reset_state", 64'(cur_snap()), 64'(idle_snap()));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("alu_rr",  2'b00, 4'h0, 3'd1, 3'd2, 3'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 16'h0, 1'b0);
      run_op("alu_ri",  2'b01, 4'h5, 3'd3, 3'd7, 3'd6, 16'h1234, 1'b1, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      run_op("load",    2'b10, 4'h9, 3'd5, 3'd0, 3'd1, 16'h0010, 1'b0, 1'b1, 1'b0, 3, 16'hBEEF, 1'b0);
      run_op("st_pinc", 2'b11, 4'h0, 3'd6, 3'd2, 3'd0, 16'h0020, 1'b0, 1'b0, 1'b1, 1, 16'h0, 1'b0);
      run_op("store",   2'b11, 4'h3, 3'd2, 3'd4, 3'd5, 16'hA5A5, 1'b1, 1'b1, 1'b0, 2, 16'h0, 1'b0);
      run_op("ld_pinc", 2'b10, 4'h0, 3'd3, 3'd1, 3'd3, 16'h0100, 1'b0, 1'b1, 1'b1, 1, 16'h7FFF, 1'b0);
      run_op("ld_tmo",  2'b10, 4'h0, 3'd4, 3'd1, 3'd2, 16'h0200, 1'b0, 1'b1, 1'b0, 0, 16'h0, 1'b0);
      exp_q.push_back(idle_snap());
      step(1'b0, 1'b1, 16'hCAFE, "late_ack");
      exp_q.push_back(idle_snap());
      step(1'b0, 1'b0, 16'h0, "idle_after_tmo");

      // Reset while a load is waiting in ADDR
      op_kind = 2'b10; op_a = 3'd3; op_b = 3'd1; op_d = 3'd2; op_imm = 16'h0040;
      op_postinc = 1'b0; op_flags = 1'b1;
      exp_q.push_back(idle_snap());
      step(1'b1, 1'b0, 16'h0, "rst_accept");
      op_valid = 1'b0;
      check_eq("rst_req_before", 64'(mem_req), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_async_snap", 64'(cur_snap()), 64'(idle_snap()));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("post_rst", 2'b10, 4'h0, 3'd7, 3'd0, 3'd5, 16'h0033, 1'b0, 1'b0, 1'b0, 2, 16'h5A5A, 1'b0);

      // Back-to-back with op_valid held high and garbage fields while busy
      run_op("b2b_0", 2'b00, 4'hA, 3'd1, 3'd2, 3'd3, 16'h1001, 1'b1, 1'b1, 1'b0, 0, 16'h0, 1'b1);
      run_op("b2b_1", 2'b01, 4'hB, 3'd4, 3'd5, 3'd6, 16'h2002, 1'b0, 1'b0, 1'b0, 0, 16'h0, 1'b1);
      run_op("b2b_2", 2'b00, 4'hC, 3'd7, 3'd0, 3'd1, 16'h3003, 1'b1, 1'b0, 1'b0, 0, 16'h0, 1'b1);
      run_op("b2b_ld", 2'b10, 4'h0, 3'd2, 3'd3, 3'd2, 16'h4004, 1'b0, 1'b1, 1'b1, 4, 16'hFFFF, 1'b1);
      exp_q.push_back(idle_snap());
      step(1'b0, 1'b0, 16'h0, "final_idle");

      check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
